// File: rtl/ex_operand_stage.sv
// ID/EX register with MEM/WB operand forwarding, load-use stall and flush bubbles.
// Latency 1 cycle ID->EX; id_ready drops for exactly one cycle per load-use hazard.
module ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [DATA_WIDTH-1:0]    id_rd1,
  input  logic [DATA_WIDTH-1:0]    id_rd2,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic                     id_alusrc,
  input  logic [OPCODE_LENGTH-1:0] id_op,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     id_memwrite,
  input  logic                     flush,
  input  logic                     mem_regwrite,
  input  logic                     wb_regwrite,
  input  logic [REG_ADDR_W-1:0]    mem_rd,
  input  logic [REG_ADDR_W-1:0]    wb_rd,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     ex_valid,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_regwrite,
  output logic                     ex_memread,
  output logic                     ex_memwrite,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [DATA_WIDTH-1:0]    ex_pc
);

  logic [DATA_WIDTH-1:0] r_rd1, r_rd2, r_imm;
  logic [REG_ADDR_W-1:0] r_rs1, r_rs2;
  logic                  r_alusrc;
  logic                  hazard;
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

  // ex_memread is already valid-qualified, so a bubble never raises a hazard
  assign hazard = ex_memread && (ex_rd != '0) && id_valid &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign id_ready = !hazard || flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      Operation   <= '0;
      ex_rd       <= '0;
      ex_pc       <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_alusrc    <= 1'b0;
    end else if (flush || hazard) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      Operation   <= '0;
    end else begin
      // controls are qualified at capture so EX outputs need no extra gating
      ex_valid    <= id_valid;
      ex_regwrite <= id_valid && id_regwrite;
      ex_memread  <= id_valid && id_memread;
      ex_memwrite <= id_valid && id_memwrite;
      Operation   <= id_valid ? id_op : '0;
      ex_rd       <= id_rd;
      ex_pc       <= id_pc;
      r_rd1       <= id_rd1;
      r_rd2       <= id_rd2;
      r_imm       <= id_imm;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_alusrc    <= id_alusrc;
    end
  end

  // MEM is the younger producer and wins over WB; x0 is never forwarded
  always_comb begin
    fwd_a = r_rd1;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == r_rs1))
      fwd_a = mem_result;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == r_rs1))
      fwd_a = wb_result;
  end

  always_comb begin
    fwd_b = r_rd2;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == r_rs2))
      fwd_b = mem_result;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == r_rs2))
      fwd_b = wb_result;
  end

  assign SrcA          = fwd_a;
  assign SrcB          = r_alusrc ? r_imm : fwd_b;
  assign ex_store_data = fwd_b;

endmodule
